bf_scan_scheduler: RTL

Round-robin scan controller for the bit-flip monitor datapath. It time-shares one popcount/accumulate path across NUM_GROUPS sensor groups. Each enabled group gets a measurement window of programmable length, and its flip count is stored per group. An interrupt is raised when a group's count exceeds a programmed threshold. Software configures, reads and acknowledges the block through a register bus.

---
 rtl/bf_scan_scheduler.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bf_scan_scheduler.sv
// Round-robin bit-flip scan scheduler: one shared popcount/accumulate path, per-group results and threshold IRQ.
// Optional BF_SCAN_PEAK_EN adds per-group PEAK registers at 0xC+g.
module bf_scan_scheduler #(
  parameter int NUM_GROUPS  = 4,
  parameter int GROUP_WIDTH = 16,
  parameter int CNT_W       = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  localparam int SEL_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [NUM_GROUPS*GROUP_WIDTH-1:0] grp_data_i,
  input  logic                            valid_i,
  input  logic                            we_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            ready_o,
  output logic                            error_o,
  output logic [SEL_W-1:0]                sel_o,
  output logic                            busy_o,
  output logic                            irq_o
);

  // state   | meaning
  // IDLE    | waiting for RUN=1 and a non-empty MASK
  // SETTLE  | clear acc, load window counter, sample_q picks up the new group
  // MEASURE | accumulate popcount of sample_q until the window counter hits 1
  // STORE   | write RESULT[sel], raise IRQ_STATUS[sel] on acc > THRESH
  // NEXT    | advance sel to the next enabled group
  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_STORE, S_NEXT} state_t;

  localparam int PK_W  = $clog2(GROUP_WIDTH + 1);
  localparam int SUM_W = ((CNT_W > PK_W) ? CNT_W : PK_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                  state_q, state_d;
  logic                    run_q, run_d;
  logic [NUM_GROUPS-1:0]   mask_q, mask_d;
  logic [NUM_GROUPS-1:0]   irq_status_q, irq_status_d, irq_set, irq_clr;
  logic [CNT_W-1:0]        window_q, window_d, thresh_q, thresh_d;
  logic [CNT_W-1:0]        acc_q, acc_d, win_cnt_q, win_cnt_d, win_eff, acc_sat;
  logic [CNT_W-1:0]        result_q [NUM_GROUPS];
  logic [CNT_W-1:0]        result_d [NUM_GROUPS];
  logic [SEL_W-1:0]        sel_q, sel_d, sel_first, sel_next;
  logic [GROUP_WIDTH-1:0]  sample_q, sample_d;
  logic [PK_W-1:0]         pop;
  logic [SUM_W-1:0]        acc_sum;
  logic                    store_en;
  logic                    ready_q, ready_d, error_q, error_d, irq_q, irq_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    unused_wdata;

  assign unused_wdata = ^wdata_i;

  function automatic logic [PK_W-1:0] popcnt(input logic [GROUP_WIDTH-1:0] v);
    logic [PK_W-1:0] c;
    c = '0;
    for (int i = 0; i < GROUP_WIDTH; i++) c = c + PK_W'(v[i]);
    return c;
  endfunction

  always_comb begin : datapath
    pop      = popcnt(sample_q);
    acc_sum  = SUM_W'(acc_q) + SUM_W'(pop);
    acc_sat  = (acc_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : acc_sum[CNT_W-1:0];
    win_eff  = (window_q == '0) ? CNT_W'(1) : window_q;
    sample_d = grp_data_i[int'(sel_q)*GROUP_WIDTH +: GROUP_WIDTH];
  end

  // Downward loops: the last hit is the lowest / nearest enabled group.
  always_comb begin : group_pick
    int idx;
    sel_first = '0;
    sel_next  = sel_q;
    for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_first = SEL_W'(i);
    end
    for (int i = NUM_GROUPS; i >= 1; i--) begin
      idx = (int'(sel_q) + i) % NUM_GROUPS;
      if (mask_q[idx]) sel_next = SEL_W'(idx);
    end
  end

  always_comb begin : fsm
    state_d   = state_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    store_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run_q && (mask_q != '0)) begin
          sel_d   = sel_first;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        acc_d     = '0;
        win_cnt_d = win_eff;
        state_d   = run_q ? S_MEASURE : S_IDLE;
      end
      S_MEASURE: begin
        if (!run_q) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_sat;
          if (win_cnt_q == CNT_W'(1)) state_d = S_STORE;
          else win_cnt_d = win_cnt_q - CNT_W'(1);
        end
      end
      S_STORE: begin
        store_en = 1'b1;
        state_d  = run_q ? S_NEXT : S_IDLE;
      end
      S_NEXT: begin
        if (!run_q || (mask_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          sel_d   = sel_next;
          state_d = S_SETTLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : store
    irq_set = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      result_d[g] = result_q[g];
      if (store_en && (int'(sel_q) == g)) result_d[g] = acc_q;
    end
    if (store_en && (acc_q > thresh_q)) irq_set[sel_q] = 1'b1;
    irq_status_d = (irq_status_q & ~irq_clr) | irq_set;
    irq_d        = |irq_status_d;
  end

`ifdef BF_SCAN_PEAK_EN
  logic [PK_W-1:0] peak_cur_q, peak_cur_d;
  logic [PK_W-1:0] peak_q [NUM_GROUPS];
  logic [PK_W-1:0] peak_d [NUM_GROUPS];

  always_comb begin : peak
    peak_cur_d = peak_cur_q;
    if (state_q == S_SETTLE) peak_cur_d = '0;
    else if ((state_q == S_MEASURE) && (pop > peak_cur_q)) peak_cur_d = pop;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      peak_d[g] = peak_q[g];
      if (store_en && (int'(sel_q) == g)) peak_d[g] = peak_cur_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      peak_cur_q <= '0;
      for (int g = 0; g < NUM_GROUPS; g++) peak_q[g] <= '0;
    end else begin
      peak_cur_q <= peak_cur_d;
      for (int g = 0; g < NUM_GROUPS; g++) peak_q[g] <= peak_d[g];
    end
  end
`endif

  always_comb begin : bus
    int a;
    a        = int'(addr_i);
    run_d    = run_q;
    mask_d   = mask_q;
    window_d = window_q;
    thresh_d = thresh_q;
    irq_clr  = '0;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    rdata_d  = '0;
    if (valid_i) begin
      if (a == 0) begin
        if (we_i) run_d = wdata_i[0];
        else rdata_d = DATA_WIDTH'(run_q);
      end else if (a == 1) begin
        if (we_i) mask_d = wdata_i[NUM_GROUPS-1:0];
        else rdata_d = DATA_WIDTH'(mask_q);
      end else if (a == 2) begin
        if (we_i) window_d = wdata_i[CNT_W-1:0];
        else rdata_d = DATA_WIDTH'(window_q);
      end else if (a == 3) begin
        if (we_i) thresh_d = wdata_i[CNT_W-1:0];
        else rdata_d = DATA_WIDTH'(thresh_q);
      end else if (a == 4) begin
        if (we_i) irq_clr = wdata_i[NUM_GROUPS-1:0];
        else rdata_d = DATA_WIDTH'(irq_status_q);
      end else if ((a >= 8) && (a < 8 + NUM_GROUPS)) begin
        if (we_i) error_d = 1'b1;
        else rdata_d = DATA_WIDTH'(result_q[SEL_W'(a - 8)]);
`ifdef BF_SCAN_PEAK_EN
      end else if ((a >= 12) && (a < 12 + NUM_GROUPS)) begin
        if (we_i) error_d = 1'b1;
        else rdata_d = DATA_WIDTH'(peak_q[SEL_W'(a - 12)]);
`endif
      end else begin
        error_d = 1'b1;
      end
      ready_d = !error_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      run_q        <= 1'b0;
      mask_q       <= '0;
      window_q     <= '0;
      thresh_q     <= '0;
      irq_status_q <= '0;
      acc_q        <= '0;
      win_cnt_q    <= '0;
      sel_q        <= '0;
      sample_q     <= '0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      for (int g = 0; g < NUM_GROUPS; g++) result_q[g] <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      mask_q       <= mask_d;
      window_q     <= window_d;
      thresh_q     <= thresh_d;
      irq_status_q <= irq_status_d;
      acc_q        <= acc_d;
      win_cnt_q    <= win_cnt_d;
      sel_q        <= sel_d;
      sample_q     <= sample_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
      for (int g = 0; g < NUM_GROUPS; g++) result_q[g] <= result_d[g];
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = ready_q;
  assign error_o = error_q;
  assign sel_o   = sel_q;
  assign busy_o  = (state_q != S_IDLE);
  assign irq_o   = irq_q;

endmodule
